// File: rtl/a10_sata_gen_negotiator.sv
// SATA line-rate negotiator: drives a10_sata_xcvr_reconf, holds PHY reset, steps GEN3->GEN2->GEN1 on link timeout.
// Optional: define A10_SATA_GEN_STICKY_EN to retry the last linked generation first after link loss.
`ifndef SATA_GEN1
`define SATA_GEN1 2'd0
`endif
`ifndef SATA_GEN2
`define SATA_GEN2 2'd1
`endif
`ifndef SATA_GEN3
`define SATA_GEN3 2'd2
`endif

module a10_sata_gen_negotiator #(
  parameter int START_GEN    = 3,
  parameter int RST_CYCLES   = 16,
  parameter int LINK_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       link_up,
  output logic       cmd_reconfig,
  output logic [1:0] cmd_sata_gen,
  input  logic       cmd_ready,
  output logic       phy_reset,
  output logic       link_ready,
  output logic [1:0] link_gen
);

  localparam logic [2:0] ST_RECONFIG    = 3'd0;
  localparam logic [2:0] ST_RECONF_BUSY = 3'd1;
  localparam logic [2:0] ST_RECONF_DONE = 3'd2;
  localparam logic [2:0] ST_PHY_RESET   = 3'd3;
  localparam logic [2:0] ST_WAIT_LINK   = 3'd4;
  localparam logic [2:0] ST_LINKED      = 3'd5;

  // Out-of-range START_GEN collapses to GEN1
  localparam logic [1:0] START_CODE = (START_GEN == 3) ? `SATA_GEN3 :
                                      (START_GEN == 2) ? `SATA_GEN2 : `SATA_GEN1;
  localparam int TW = $clog2(LINK_TIMEOUT);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic [2:0]    state;
  logic [1:0]    gen;
  logic [TW-1:0] to_cnt;
  logic [RW-1:0] rst_cnt;

  function automatic logic [1:0] next_gen(input logic [1:0] g);
    case (g)
      `SATA_GEN3: next_gen = `SATA_GEN2;
      `SATA_GEN2: next_gen = `SATA_GEN1;
      default:    next_gen = START_CODE;
    endcase
  endfunction

  assign cmd_sata_gen = gen;
  assign link_gen     = gen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_RECONFIG;
      gen          <= START_CODE;
      cmd_reconfig <= 1'b0;
      phy_reset    <= 1'b1;
      link_ready   <= 1'b0;
      to_cnt       <= '0;
      rst_cnt      <= '0;
    end else begin
      case (state)
        ST_RECONFIG: begin
          phy_reset <= 1'b1;
          // Request only tracks cmd_ready, so a busy reconfigurator after reset is never re-issued to
          if (cmd_reconfig && cmd_ready) begin
            cmd_reconfig <= 1'b0;
            state        <= ST_RECONF_BUSY;
          end else begin
            cmd_reconfig <= cmd_ready;
          end
        end
        ST_RECONF_BUSY: if (!cmd_ready) state <= ST_RECONF_DONE;
        ST_RECONF_DONE: begin
          if (cmd_ready) begin
            state   <= ST_PHY_RESET;
            rst_cnt <= '0;
          end
        end
        ST_PHY_RESET: begin
          if (rst_cnt == RW'(RST_CYCLES - 1)) begin
            state     <= ST_WAIT_LINK;
            to_cnt    <= '0;
            phy_reset <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        ST_WAIT_LINK: begin
          to_cnt <= to_cnt + 1'b1;
          if (link_up) begin
            state <= ST_LINKED;
          end else if (to_cnt == TW'(LINK_TIMEOUT - 1)) begin
            gen       <= next_gen(gen);
            state     <= ST_RECONFIG;
            phy_reset <= 1'b1;
          end
        end
        ST_LINKED: begin
          link_ready <= link_up;
          if (!link_up) begin
            state     <= ST_RECONFIG;
            phy_reset <= 1'b1;
`ifdef A10_SATA_GEN_STICKY_EN
            gen       <= gen;
`else
            gen       <= START_CODE;
`endif
          end
        end
        default: state <= ST_RECONFIG;
      endcase
    end
  end

endmodule
